// File: rtl/mult_unit_if.sv
// Execute-stage multiplier handshake bundle.
// master: pipeline/hazard side (drives MultStart, MultSigned, MultAbort, SrcA, SrcB)
// slave : multiplier (drives Busy, ProdV, Hi, Lo)
interface mult_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             MultStart;
    logic             MultSigned;
    logic             MultAbort;
    logic [WIDTH-1:0] SrcA;
    logic [WIDTH-1:0] SrcB;
    logic             Busy;
    logic             ProdV;
    logic [WIDTH-1:0] Hi;
    logic [WIDTH-1:0] Lo;

    modport master (
        output MultStart, MultSigned, MultAbort, SrcA, SrcB,
        input  Busy, ProdV, Hi, Lo
    );

    modport slave (
        input  MultStart, MultSigned, MultAbort, SrcA, SrcB,
        output Busy, ProdV, Hi, Lo
    );
endinterface

// File: rtl/mult_unit.sv
// Iterative shift-add multiplier (MULT/MULTU) for the execute stage.
// Magnitudes are multiplied unsigned, BITS_PER_CYCLE multiplier bits per BUSY
// cycle; the sign is applied once in FIX. ProdV pulses for one cycle in DONE.
// Ports:
//   clk      - clock, rising edge
//   reset_n  - asynchronous active-low reset
//   mif      - mult_unit_if.slave: MultStart/MultSigned/MultAbort/SrcA/SrcB in,
//              Busy/ProdV/Hi/Lo out
// Optional feature: define MULT_EARLY_OUT_EN to leave BUSY as soon as the
// remaining multiplier is zero (data-dependent latency, identical results).
module mult_unit #(
    parameter int unsigned WIDTH          = 32,
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    mult_unit_if.slave  mif
);

    localparam int unsigned N  = WIDTH / BITS_PER_CYCLE;
    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned CW = $clog2(N + 1);
    localparam int unsigned DW = WIDTH + BITS_PER_CYCLE;
    localparam int unsigned SW = $clog2(PW);

`ifdef MULT_EARLY_OUT_EN
    localparam bit EARLY_OUT = 1'b1;
`else
    localparam bit EARLY_OUT = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t state, next_state;

    logic [WIDTH-1:0]          a_mag;
    logic [WIDTH-1:0]          b_rem;
    logic [PW-1:0]             acc;
    logic [CW-1:0]             count;
    logic                      sign;
    logic                      load;
    logic                      iterate;
    logic                      commit;

    logic [WIDTH-1:0]          src_a_mag;
    logic [WIDTH-1:0]          src_b_mag;
    logic [BITS_PER_CYCLE-1:0] digit;
    logic [DW-1:0]             partial;
    logic [SW-1:0]             shamt;
    logic [PW-1:0]             addend;
    logic [PW-1:0]             result;

    // Operand magnitudes; the most-negative value maps to 2^(WIDTH-1), still unsigned-representable
    always_comb begin
        src_a_mag = mif.SrcA;
        src_b_mag = mif.SrcB;
        if (mif.MultSigned && mif.SrcA[WIDTH-1]) begin
            src_a_mag = (~mif.SrcA) + WIDTH'(1);
        end
        if (mif.MultSigned && mif.SrcB[WIDTH-1]) begin
            src_b_mag = (~mif.SrcB) + WIDTH'(1);
        end
    end

    // Partial product for the current multiplier digit, aligned to its weight
    always_comb begin
        digit   = b_rem[BITS_PER_CYCLE-1:0];
        partial = DW'(a_mag) * DW'(digit);
        shamt   = SW'(count) * SW'(BITS_PER_CYCLE);
        addend  = PW'(partial) << shamt;
        result  = sign ? ((~acc) + PW'(1)) : acc;
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state, datapath strobes and status decode
    always_comb begin
        next_state = state;
        load       = 1'b0;
        iterate    = 1'b0;
        commit     = 1'b0;
        mif.Busy   = 1'b0;
        mif.ProdV  = 1'b0;
        case (state)
            S_IDLE: begin
                if (mif.MultStart && !mif.MultAbort) begin
                    load       = 1'b1;
                    next_state = S_BUSY;
                end
            end
            S_BUSY: begin
                mif.Busy = 1'b1;
                if (mif.MultAbort) begin
                    next_state = S_IDLE;
                end else if (EARLY_OUT && (b_rem == '0)) begin
                    next_state = S_FIX;
                end else begin
                    iterate = 1'b1;
                    if (count == CW'(N - 1)) begin
                        next_state = S_FIX;
                    end
                end
            end
            S_FIX: begin
                mif.Busy = 1'b1;
                if (mif.MultAbort) begin
                    next_state = S_IDLE;
                end else begin
                    commit     = 1'b1;
                    next_state = S_DONE;
                end
            end
            S_DONE: begin
                // Result is already committed; abort and start are both ignored here
                mif.ProdV  = 1'b1;
                next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Operand, accumulator and result registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_mag   <= '0;
            b_rem   <= '0;
            acc     <= '0;
            count   <= '0;
            sign    <= 1'b0;
            mif.Hi  <= '0;
            mif.Lo  <= '0;
        end else begin
            if (load) begin
                a_mag <= src_a_mag;
                b_rem <= src_b_mag;
                sign  <= mif.MultSigned & (mif.SrcA[WIDTH-1] ^ mif.SrcB[WIDTH-1]);
                acc   <= '0;
                count <= '0;
            end else if (iterate) begin
                acc   <= acc + addend;
                b_rem <= b_rem >> BITS_PER_CYCLE;
                count <= count + CW'(1);
            end
            if (commit) begin
                mif.Hi <= result[PW-1:WIDTH];
                mif.Lo <= result[WIDTH-1:0];
            end
        end
    end

endmodule

// File: tb/tb_mult_unit.sv
// Scoreboard bench for mult_unit: stimulus pushes expected {Hi,Lo} and the
// cycle ProdV must appear; an independent monitor pops on every ProdV.
module tb_mult_unit;

    logic clk;
    logic reset_n;
    int   cyc;
    int   vectors;
    int   miscompares;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          due;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] last_hi;
    logic [31:0] last_lo;

    mult_unit_if #(.WIDTH(32)) mif ();

    mult_unit #(
        .WIDTH          (32),
        .BITS_PER_CYCLE (1)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .mif     (mif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: full-width product from plain arithmetic
    function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b, input bit sgn);
        longint sa;
        longint sb;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return 64'(sa * sb);
        end
        return {32'b0, a} * {32'b0, b};
    endfunction

    // Reference: edges from the start sample until ProdV is visible
    function automatic int ref_lat(input logic [31:0] b, input bit sgn);
`ifdef MULT_EARLY_OUT_EN
        logic [31:0] m;
        int          bits;
        m    = (sgn && b[31]) ? 32'(0 - b) : b;
        bits = 0;
        for (int i = 0; i < 32; i++) if (m[i]) bits = i + 1;
        return (bits == 32) ? 33 : bits + 2;
`else
        return (sgn || !sgn) ? 33 : 0;
`endif
    endfunction

    function automatic logic [31:0] rand_opnd();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((mif.Busy || mif.ProdV) && n < 200) begin
            step();
            n++;
        end
        if (n >= 200) chk("idle_timeout", 64'(n), 64'(0));
    endtask

    // Issue one multiply; hold = extra cycles MultStart stays high with junk operands
    task automatic op(input logic [31:0] a, input logic [31:0] b, input bit sgn,
                      input int hold, input bit abort_done);
        exp_t        e;
        logic [63:0] p;
        int          lat;
        wait_idle();
        p     = ref_prod(a, b, sgn);
        lat   = ref_lat(b, sgn);
        e.hi  = p[63:32];
        e.lo  = p[31:0];
        e.due = cyc + 1 + lat;
        exp_q.push_back(e);
        last_hi = e.hi;
        last_lo = e.lo;
        mif.MultStart  = 1'b1;
        mif.MultSigned = sgn;
        mif.SrcA       = a;
        mif.SrcB       = b;
        step();
        repeat (hold) begin
            mif.SrcA       = $urandom;
            mif.SrcB       = $urandom;
            mif.MultSigned = 1'($urandom_range(0, 1));
            step();
        end
        mif.MultStart = 1'b0;
        mif.SrcA      = $urandom;
        mif.SrcB      = $urandom;
        if (abort_done) begin
            repeat (lat - hold) step();
            mif.MultAbort = 1'b1;
            step();
            mif.MultAbort = 1'b0;
        end
    endtask

    // Monitor: every ProdV must match the head of the scoreboard at its due cycle
    initial begin
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (mif.ProdV) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_prodv", 64'(1), 64'(0));
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        chk("prodv_cycle", 64'(cyc), 64'(e.due));
                        chk("hi", 64'(mif.Hi), 64'(e.hi));
                        chk("lo", 64'(mif.Lo), 64'(e.lo));
                        chk("busy_in_done", 64'(mif.Busy), 64'(0));
                    end
                end else if (exp_q.size() != 0 && cyc > exp_q[0].due) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("prodv_missing", 64'(cyc), 64'(e.due));
                end
            end
        end
    end

    initial begin
        int n;
        bit s;
        int h;
        int l;
        logic [31:0] a;
        logic [31:0] b;
        vectors        = 0;
        miscompares    = 0;
        cyc            = 0;
        last_hi        = '0;
        last_lo        = '0;
        reset_n        = 1'b0;
        mif.MultStart  = 1'b0;
        mif.MultSigned = 1'b0;
        mif.MultAbort  = 1'b0;
        mif.SrcA       = '0;
        mif.SrcB       = '0;
        repeat (3) step();
        chk("rst_busy", 64'(mif.Busy), 64'(0));
        chk("rst_prodv", 64'(mif.ProdV), 64'(0));
        chk("rst_hi", 64'(mif.Hi), 64'(0));
        chk("rst_lo", 64'(mif.Lo), 64'(0));
        reset_n = 1'b1;
        step();

        // Directed corner operands
        op(32'd3, 32'd5, 1'b0, 0, 1'b0);
        op(32'hFFFF_FFFD, 32'd7, 1'b1, 0, 1'b0);
        op(32'hFFFF_FFFD, 32'd7, 1'b0, 0, 1'b0);
        op(32'h8000_0000, 32'h8000_0000, 1'b1, 0, 1'b0);
        op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, 1'b0);
        op(32'h1234_5678, 32'd0, 1'b1, 0, 1'b0);
        op(32'h1234_5678, 32'd1, 1'b0, 0, 1'b0);
        op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, 1'b0);

        // Reset in the middle of BUSY clears everything asynchronously
        wait_idle();
        mif.MultStart = 1'b1;
        mif.SrcA      = 32'd9;
        mif.SrcB      = 32'd9;
        step();
        mif.MultStart = 1'b0;
        repeat (5) step();
        reset_n = 1'b0;
        #1;
        chk("midrst_busy", 64'(mif.Busy), 64'(0));
        chk("midrst_prodv", 64'(mif.ProdV), 64'(0));
        chk("midrst_hi", 64'(mif.Hi), 64'(0));
        chk("midrst_lo", 64'(mif.Lo), 64'(0));
        step();
        reset_n = 1'b1;
        step();

        // Abort during BUSY: prior result 0x15 must survive, no ProdV
        op(32'd3, 32'd7, 1'b0, 0, 1'b0);
        wait_idle();
        mif.MultStart  = 1'b1;
        mif.MultSigned = 1'b0;
        mif.SrcA       = 32'hFFFF_FFFF;
        mif.SrcB       = 32'hFFFF_FFFF;
        step();
        repeat (10) step();
        mif.MultStart = 1'b0;
        mif.MultAbort = 1'b1;
        step();
        mif.MultAbort = 1'b0;
        chk("abort_busy", 64'(mif.Busy), 64'(0));
        repeat (40) step();
        chk("abort_hi", 64'(mif.Hi), 64'(last_hi));
        chk("abort_lo", 64'(mif.Lo), 64'(last_lo));

        // Abort together with start in IDLE: nothing accepted
        mif.MultStart = 1'b1;
        mif.MultAbort = 1'b1;
        step();
        mif.MultStart = 1'b0;
        mif.MultAbort = 1'b0;
        chk("abort_idle_busy", 64'(mif.Busy), 64'(0));
        repeat (40) step();

        // Abort in DONE is harmless
        op(32'd11, 32'hFFFF_FFF0, 1'b1, 0, 1'b1);

        // Randomized traffic with held MultStart and late aborts
        for (int i = 0; i < 40; i++) begin
            a = rand_opnd();
            b = rand_opnd();
            s = 1'($urandom_range(0, 1));
            l = ref_lat(b, s);
            h = $urandom_range(0, (l - 1 < 20) ? l - 1 : 20);
            op(a, b, s, h, ($urandom_range(0, 7) == 0));
        end

        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            step();
            n++;
        end
        if (exp_q.size() != 0) chk("drain", 64'(exp_q.size()), 64'(0));
        step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
